// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, receiver state encoding
// and default clock/baud settings used by the receiver and transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int DATA_W        = 8;
  localparam int DEF_CLK_FREQ  = 50_000_000;
  localparam int DEF_BAUD_RATE = 19_200;

endpackage

// File: rtl/uart_rx_stream_if.sv
// Valid/ready byte stream leaving the UART receiver.
// The master holds rx_data stable while rx_valid is high.
interface uart_rx_stream_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks.
// clr_i holds the divider at zero so the next tick is phase-aligned.
module uart_baud_tick #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 19_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    tick_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_o = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver with 3-sample majority voting and a
// valid/ready output register reporting framing and overrun errors.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD_RATE  = DEF_BAUD_RATE,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  uart_rx_stream_if.master rx_if,
  output logic             frame_err,
  output logic             overrun,
  output logic             rx_busy
);

  localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] S_MID  = 4'(OVERSAMPLE / 2);
  localparam logic [3:0] S_SMID = 4'(OVERSAMPLE / 2 - 1);

  logic              rx_s1_q, rx_s2_q;
  logic [1:0]        sv_q;
  logic              arm_q, arm_d;
  uart_state_e       state_q, state_d;
  logic [3:0]        samp_q, samp_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        sh_q, sh_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ovr_q;
  logic              tick, rxs, maj, hs;
  logic              stop_ok, stop_bad;

  assign rxs = rx_s2_q;
  assign maj = (sh_q[1] & sh_q[0]) | (sh_q[1] & rxs) | (sh_q[0] & rxs);
  assign hs  = valid_q & rx_if.rx_ready;

  uart_baud_tick #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == IDLE),
    .tick_o (tick)
  );

  // sv_q marks when the synchronizer holds real line samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      sv_q    <= '0;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      sv_q    <= {sv_q[0], 1'b1};
    end
  end

  always_comb begin
    state_d  = state_q;
    samp_d   = samp_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    shift_d  = shift_q;
    arm_d    = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    if (tick) begin
      samp_d = (samp_q == S_LAST) ? '0 : samp_q + 4'd1;
      sh_d   = {sh_q[0], rxs};
    end
    case (state_q)
      IDLE: begin
        samp_d = '0;
        bit_d  = '0;
        arm_d  = arm_q | (sv_q[1] & rxs);
        if (arm_q && !rxs) state_d = START;
      end
      // a valid start runs to its end so data bits begin at index 0
      START: begin
        if (tick) begin
          if (samp_q == S_SMID && maj) begin
            state_d = IDLE;
          end else if (samp_q == S_LAST) begin
            samp_d  = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (samp_q == S_MID) shift_d = {maj, shift_q[DATA_W-1:1]};
          if (samp_q == S_LAST) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick && samp_q == S_MID) begin
          state_d  = IDLE;
          stop_ok  = maj;
          stop_bad = !maj;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (hs) valid_d = 1'b0;
    if (stop_ok && (!valid_q || hs)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      arm_q   <= 1'b0;
      samp_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '1;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= stop_bad;
      ovr_q   <= stop_ok & valid_q & ~hs;
    end
  end

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign frame_err      = ferr_q;
  assign overrun        = ovr_q;
  assign rx_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream: good frames, false start,
// framing error, overrun, mid-frame reset and baud skew.
module tb_uart_rx_stream;
  import uart_pkg::*;

  localparam int CLKF = 3_072_000;
  localparam int BAUD = 19_200;
  localparam int OS   = 16;
  localparam int BITC = 160;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;
  logic frame_err, overrun, rx_busy;

  uart_rx_stream_if sif ();

  uart_rx_stream #(
    .CLK_FREQ   (CLKF),
    .BAUD_RATE  (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_if     (sif),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int vcyc = 0, fecnt = 0, ovcnt = 0, hscnt = 0, bad_pulse = 0;
  logic [7:0] hs_last = 8'h00;
  logic fe_p = 1'b0, ov_p = 1'b0;

  always @(negedge clk) begin
    if (sif.rx_valid) vcyc++;
    if (frame_err) fecnt++;
    if (overrun) ovcnt++;
    if (sif.rx_valid && sif.rx_ready) begin
      hscnt++;
      hs_last = sif.rx_data;
    end
    if ((frame_err && overrun) || (frame_err && fe_p) || (overrun && ov_p))
      bad_pulse++;
    fe_p = frame_err;
    ov_p = overrun;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stopb, input int bc);
    rx = 1'b0;
    tk(bc);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tk(bc);
    end
    rx = stopb;
    tk(bc);
    rx = 1'b1;
  endtask

  int b_h, b_v, b_f, b_o;

  initial begin
    sif.rx_ready = 1'b1;
    tk(3);
    chk("rst_valid", 32'(sif.rx_valid), 32'h0);
    chk("rst_data", 32'(sif.rx_data), 32'h00);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(rx_busy), 32'h0);
    rst = 1'b1;
    tk(5);

    b_h = hscnt; b_v = vcyc; b_f = fecnt;
    send(8'hA5, 1'b1, BITC);
    tk(BITC);
    chk("a5_hs", 32'(hscnt - b_h), 32'd1);
    chk("a5_data", 32'(hs_last), 32'hA5);
    chk("a5_vcyc", 32'(vcyc - b_v), 32'd1);
    chk("a5_ferr", 32'(fecnt - b_f), 32'd0);
    chk("a5_hold", 32'(sif.rx_data), 32'hA5);

    b_v = vcyc;
    rx = 1'b0;
    tk(48);
    chk("glitch_busy", 32'(rx_busy), 32'h1);
    rx = 1'b1;
    tk(60);
    chk("glitch_idle", 32'(rx_busy), 32'h0);
    chk("glitch_vcyc", 32'(vcyc - b_v), 32'd0);

    b_v = vcyc; b_f = fecnt;
    send(8'h3C, 1'b0, BITC);
    tk(2 * BITC);
    chk("ferr_cnt", 32'(fecnt - b_f), 32'd1);
    chk("ferr_vcyc", 32'(vcyc - b_v), 32'd0);
    chk("ferr_data", 32'(sif.rx_data), 32'hA5);
    chk("ferr_valid", 32'(sif.rx_valid), 32'h0);

    sif.rx_ready = 1'b0;
    b_o = ovcnt; b_f = fecnt;
    send(8'h11, 1'b1, BITC);
    send(8'h22, 1'b1, BITC);
    tk(BITC);
    chk("ovr_data", 32'(sif.rx_data), 32'h11);
    chk("ovr_valid", 32'(sif.rx_valid), 32'h1);
    chk("ovr_cnt", 32'(ovcnt - b_o), 32'd1);
    chk("ovr_ferr", 32'(fecnt - b_f), 32'd0);
    sif.rx_ready = 1'b1;
    tk(3);
    chk("ovr_drain", 32'(sif.rx_valid), 32'h0);
    chk("ovr_hsdata", 32'(hs_last), 32'h11);

    b_h = hscnt; b_o = ovcnt; b_f = fecnt;
    rx = 1'b0;
    tk(BITC);
    rx = 1'b1;
    tk(3 * BITC);
    rst = 1'b0;
    tk(2);
    chk("mrst_busy", 32'(rx_busy), 32'h0);
    chk("mrst_data", 32'(sif.rx_data), 32'h00);
    tk(3);
    rst = 1'b1;
    tk(6 * BITC);
    chk("mrst_idle", 32'(rx_busy), 32'h0);
    send(8'h5A, 1'b1, BITC);
    tk(BITC);
    chk("mrst_hs", 32'(hscnt - b_h), 32'd1);
    chk("mrst_5a", 32'(hs_last), 32'h5A);
    chk("mrst_ferr", 32'(fecnt - b_f), 32'd0);
    chk("mrst_ovr", 32'(ovcnt - b_o), 32'd0);

    b_h = hscnt;
    send(8'h55, 1'b1, 165);
    tk(165);
    chk("slow_hs", 32'(hscnt - b_h), 32'd1);
    chk("slow_data", 32'(hs_last), 32'h55);
    send(8'h55, 1'b1, 155);
    tk(155);
    chk("fast_hs", 32'(hscnt - b_h), 32'd2);
    chk("fast_data", 32'(hs_last), 32'h55);

    chk("pulse_rules", 32'(bad_pulse), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_stream.md
UART_RX_STREAM -- requirements
Module: uart_rx_stream

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 19200, line bit rate in bits per second.
REQ-003 Parameter OVERSAMPLE, default 16, sample ticks per bit period; legal values are 8 or 16.
REQ-004 One clock and an asynchronous, active-low reset: clk (rising edge) and rst (asserted low, takes effect without a clock edge).
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 rx  input  1  asynchronous serial line: idle high, 8N1 framing, LSB first.
REQ-008 rx_data  output  8  received byte, stable while rx_valid is high.
REQ-009 rx_valid  output  1  a byte is held in rx_data.
REQ-010 rx_ready  input  1  the consumer accepts the byte when rx_valid and rx_ready are both high on a rising edge.
REQ-011 frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-012 overrun  output  1  one-cycle pulse when a good byte completes while rx_valid is already high.
REQ-013 rx_busy  output  1  high in every state except IDLE.

Function
REQ-014 rx passes through a two-flop synchronizer reset to 1; all decoding uses the synchronized value.
REQ-015 Tick generator: a one-cycle tick every DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks (integer division; 162 at defaults). The counter wraps at DIV-1.
REQ-016 The tick counter is held at 0 in IDLE and restarts on the clock after start detection, so that the first tick is phase-aligned to the falling edge.
REQ-017 State machine states: IDLE, START, DATA, STOP.
REQ-018 IDLE -> START on the first clock where synchronized rx is 0.
REQ-019 START: at tick index OVERSAMPLE/2-1, if the majority of samples is 1, the start is false and the FSM returns to IDLE with no output. Otherwise the sample counter is zeroed and the FSM goes to DATA.
REQ-020 Bit value: majority of three samples taken at tick indices OVERSAMPLE/2-2, OVERSAMPLE/2-1 and OVERSAMPLE/2. The decision is made at OVERSAMPLE/2.
REQ-021 DATA: eight bits are shifted in LSB first, each spanning OVERSAMPLE ticks. After the 8th bit, the FSM goes to STOP.
REQ-022 STOP: the bit is decided at its mid-point, and the FSM then returns to IDLE immediately; the second half of the stop bit is not waited out.
REQ-023 Stop bit = 1 with rx_valid low: load rx_data and set rx_valid on the next edge.
REQ-024 Stop bit = 1 with rx_valid high and no handshake in the same cycle: pulse overrun, drop the new byte, and leave rx_data unchanged.
REQ-025 Stop bit = 1 in the same cycle as a handshake: the handshake completes, the new byte loads, rx_valid stays high, and there is no overrun.
REQ-026 Stop bit = 0: pulse frame_err, discard the byte, and leave rx_valid and rx_data unchanged.
REQ-027 rx_valid clears on the edge after a handshake. rx_data never changes while rx_valid is high, except under REQ-025.
REQ-028 Latency: rx_valid rises one clk after the stop-bit mid-point decision.
REQ-029 frame_err and overrun are mutually exclusive and never last more than one cycle.

Reset
REQ-030 While rst is low: FSM = IDLE, counters = 0, synchronizer = 1, rx_data = 8'h00, rx_valid = 0, frame_err = 0, overrun = 0, rx_busy = 0.
REQ-031 Reset asserted mid-frame abandons the frame with no output pulse. After deassertion, a start is not accepted until synchronized rx has been seen at 1.

Structure
REQ-032 Shared package uart_pkg holds the FSM state enum (IDLE, START, DATA, STOP), the frame data width constant (8) and the default CLK_FREQ and BAUD_RATE values; the existing UART transmitter also uses it.
REQ-033 One sub-module, uart_baud_tick, contains the divider and the OVERSAMPLE tick generator with its clear input. Synchronizer, FSM and output register remain in uart_rx_stream.
REQ-034 The block is intended to replace the receiver instance in the UART top level without changing the top-level ports, except for the added handshake and error pins.

Verification
REQ-035 Byte 8'hA5 at 19200 baud with rx_ready held high -> rx_data = 8'hA5, rx_valid high for exactly 1 cycle, frame_err = 0.
REQ-036 A 0.3-bit low glitch on an idle line -> false start rejected, rx_valid stays 0, rx_busy returns to 0 within OVERSAMPLE/2 ticks.
REQ-037 Byte 8'h3C with a stop bit of 0 -> one frame_err pulse, rx_valid stays 0.
REQ-038 8'h11 then 8'h22 back-to-back with rx_ready = 0 -> rx_data stays 8'h11, one overrun pulse at the second stop mid-point.
REQ-039 rst pulled low mid-DATA of 8'hFF, then released, then 8'h5A sent -> only 8'h5A delivered, with no error pulses.
REQ-040 Frames of 8'h55 with the bit period skewed +/-3% -> all bytes received correctly.
